// File: rtl/gpio_port_ctrl.sv
// Register-mapped controller for a bank of bidirectional GPIO pads: pad drive
// configuration, synchronised inputs, edge interrupts and a strobe register port.
module gpio_port_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rd_valid,
    output logic [WIDTH-1:0] pad_a,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] pad_pu,
    output logic [WIDTH-1:0] pad_pd,
    input  logic [WIDTH-1:0] pad_y,
    output logic             irq
);

    localparam logic [2:0] A_DIR  = 3'd0;
    localparam logic [2:0] A_OUT  = 3'd1;
    localparam logic [2:0] A_PU   = 3'd2;
    localparam logic [2:0] A_PD   = 3'd3;
    localparam logic [2:0] A_IN   = 3'd4;
    localparam logic [2:0] A_RISE = 3'd5;
    localparam logic [2:0] A_FALL = 3'd6;
    localparam logic [2:0] A_STAT = 3'd7;

    logic [WIDTH-1:0] dir_q, out_q, pu_q, pd_q, rise_en_q, fall_en_q, stat_q;
    logic [WIDTH-1:0] dir_d, out_d, pu_d, pd_d, rise_en_d, fall_en_d, stat_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] rdata_q, rdata_d, rd_mux;
    logic             rd_valid_q, irq_q;
    logic [WIDTH-1:0] pad_a_q, pad_oe_q, pad_pu_q, pad_pd_q;
    logic [WIDTH-1:0] clr, rise, fall;

    // Strobe port: wr_en/rd_en are single-cycle requests that are always
    // accepted (no ready); each rd_en yields exactly one rd_valid pulse on the
    // following cycle, and rdata holds its last value between pulses.
    always_comb begin
        dir_d     = dir_q;
        out_d     = out_q;
        pu_d      = pu_q;
        pd_d      = pd_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr_en) begin
            case (addr)
                A_DIR:   dir_d     = wdata;
                A_OUT:   out_d     = wdata;
                A_PU:    pu_d      = wdata;
                A_PD:    pd_d      = wdata;
                A_RISE:  rise_en_d = wdata;
                A_FALL:  fall_en_d = wdata;
                A_STAT:  clr       = wdata;
                default: ;
            endcase
        end
        rise   = sync2_q & ~prev_q & rise_en_q;
        fall   = ~sync2_q & prev_q & fall_en_q;
        // New events are OR-ed in after the clear so a coinciding set wins.
        stat_d = (stat_q & ~clr) | rise | fall;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_DIR:   rd_mux = dir_q;
            A_OUT:   rd_mux = out_q;
            A_PU:    rd_mux = pu_q;
            A_PD:    rd_mux = pd_q;
            A_IN:    rd_mux = sync2_q;
            A_RISE:  rd_mux = rise_en_q;
            A_FALL:  rd_mux = fall_en_q;
            A_STAT:  rd_mux = stat_q;
            default: rd_mux = '0;
        endcase
        rdata_d = rd_en ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q      <= '0;
            out_q      <= '0;
            pu_q       <= '0;
            pd_q       <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            stat_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
            pad_a_q    <= '0;
            pad_oe_q   <= '0;
            pad_pu_q   <= '0;
            pad_pd_q   <= '0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            pu_q       <= pu_d;
            pd_q       <= pd_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            stat_q     <= stat_d;
            sync1_q    <= pad_y;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_en;
            irq_q      <= |stat_d;
            // Pull-down beats pull-up; pulls are off on driven pins.
            pad_oe_q   <= dir_q;
            pad_a_q    <= out_q & dir_q;
            pad_pd_q   <= pd_q & ~dir_q;
            pad_pu_q   <= pu_q & ~pd_q & ~dir_q;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;
    assign pad_a    = pad_a_q;
    assign pad_oe   = pad_oe_q;
    assign pad_pu   = pad_pu_q;
    assign pad_pd   = pad_pd_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Self-checking bench for gpio_port_ctrl: directed scenarios followed by a
// randomized phase, all checked against a history-based reference model.
module tb_gpio_port_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [2:0]   addr = '0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] ext_y = '0;
    logic [W-1:0] rdata, pad_a, pad_oe, pad_pu, pad_pd, pad_y;
    logic         rd_valid, irq;

    // Pad cell: driven pins loop their output back to the receiver.
    assign pad_y = (pad_oe & pad_a) | (~pad_oe & ext_y);

    gpio_port_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid), .pad_a(pad_a),
        .pad_oe(pad_oe), .pad_pu(pad_pu), .pad_pd(pad_pd), .pad_y(pad_y), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: register file plus the last three sampled pad values.
    logic [W-1:0] m_cfg [8];
    logic [W-1:0] m_stat, m_rdata, h1, h2, h3;
    logic [W-1:0] m_oe, m_a, m_pu, m_pd;
    logic         m_rdv, m_irq;
    int           total = 0;
    int           bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cfg[i] = '0;
        m_stat = '0; m_rdata = '0; h1 = '0; h2 = '0; h3 = '0;
        m_oe = '0; m_a = '0; m_pu = '0; m_pd = '0; m_rdv = 1'b0; m_irq = 1'b0;
    endtask

    task automatic check_all();
        chk("rd_valid", rd_valid, m_rdv);
        chk("rdata", rdata, m_rdata);
        chk("irq", irq, m_irq);
        chk("pad_oe", pad_oe, m_oe);
        chk("pad_a", pad_a, m_a);
        chk("pad_pu", pad_pu, m_pu);
        chk("pad_pd", pad_pd, m_pd);
    endtask

    // One clock: predict the effect of the edge, take it, then compare.
    // IN seen before an edge is the pad value two edges back; an event is
    // latched when that value differs from the one three edges back.
    task automatic step();
        logic [W-1:0] y_now, rise, fall, clr, ns;
        @(negedge clk);
        y_now = pad_y;
        rise  = h2 & ~h3 & m_cfg[5];
        fall  = ~h2 & h3 & m_cfg[6];
        clr   = (wr_en && addr == 3'd7) ? wdata : '0;
        ns    = (m_stat & ~clr) | rise | fall;
        m_rdv = rd_en;
        if (rd_en) m_rdata = (addr == 3'd4) ? h2 : (addr == 3'd7) ? m_stat : m_cfg[addr];
        m_oe = m_cfg[0];
        m_a  = m_cfg[1] & m_cfg[0];
        m_pd = m_cfg[3] & ~m_cfg[0];
        m_pu = m_cfg[2] & ~m_cfg[3] & ~m_cfg[0];
        if (wr_en && addr != 3'd4 && addr != 3'd7) m_cfg[addr] = wdata;
        m_stat = ns;
        m_irq  = |ns;
        h3 = h2; h2 = h1; h1 = y_now;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en = 1'b1; addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Pad drive configuration.
        wr(3'd0, 8'hF0); wr(3'd1, 8'hAA); wr(3'd2, 8'hFF); wr(3'd3, 8'h0F);
        step();
        chk("drive_oe", pad_oe, 8'hF0);
        chk("drive_a", pad_a, 8'hA0);
        chk("drive_pd", pad_pd, 8'h0F);
        chk("drive_pu", pad_pu, 8'h00);

        // Input synchroniser latency seen through IN.
        wr(3'd0, 8'h00);
        idle(3);
        ext_y = 8'h5A;
        step();
        rd(3'd4);
        chk("in_early", rdata, 8'h00);
        rd(3'd4);
        chk("in_late", rdata, 8'h5A);
        chk("in_valid", rd_valid, 1'b1);
        step();
        chk("in_valid_drop", rd_valid, 1'b0);

        // Edge interrupts.
        ext_y = 8'h80;
        idle(3);
        wr(3'd5, 8'h01); wr(3'd6, 8'h80);
        ext_y = 8'h01;
        step(); chk("irq_n0", irq, 1'b0);
        step(); chk("irq_n1", irq, 1'b0);
        step(); chk("irq_n2", irq, 1'b1);
        rd(3'd7); chk("stat_both", rdata, 8'h81);
        wr(3'd7, 8'h01); chk("irq_after_clr0", irq, 1'b1);
        rd(3'd7); chk("stat_bit7", rdata, 8'h80);
        wr(3'd7, 8'h80); chk("irq_cleared", irq, 1'b0);

        // Clear and set of the same bit on the same edge: set wins.
        ext_y = 8'h00; idle(3);
        ext_y = 8'h01; idle(3);
        chk("irq_pin0", irq, 1'b1);
        ext_y = 8'h00; idle(2);
        ext_y = 8'h01; idle(2);
        wr(3'd7, 8'h01);
        chk("collide_irq", irq, 1'b1);
        rd(3'd7); chk("collide_stat", rdata, 8'h01);
        wr(3'd7, 8'h01); chk("collide_clr", irq, 1'b0);

        // Same-cycle read and write, and a write to IN.
        wr(3'd1, 8'h11);
        wr_en = 1'b1; rd_en = 1'b1; addr = 3'd1; wdata = 8'h22;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rw_old", rdata, 8'h11);
        rd(3'd1); chk("rw_new", rdata, 8'h22);
        wr(3'd4, 8'hFF);
        rd(3'd4); chk("in_ro", rdata, 8'h01);

        // Asynchronous reset in the middle of a read and a write.
        wr(3'd0, 8'h3C);
        wr(3'd5, 8'hFF);
        step();
        ext_y = 8'h00;
        rd_en = 1'b1; wr_en = 1'b1; addr = 3'd2; wdata = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_oe", pad_oe, 8'h00);
        chk("rst_a", pad_a, 8'h00);
        chk("rst_pu", pad_pu, 8'h00);
        chk("rst_pd", pad_pd, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_rdv", rd_valid, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        model_reset();
        rd_en = 1'b0; wr_en = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_rdv", rd_valid, 1'b0);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            chk($sformatf("rst_reg%0d", a), rdata, 8'h00);
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) ext_y = W'($urandom);
            case ($urandom_range(0, 3))
                0: begin wr_en = 1'b1; addr = 3'($urandom); wdata = W'($urandom); end
                1: begin rd_en = 1'b1; addr = 3'($urandom); end
                2: begin wr_en = 1'b1; rd_en = 1'b1; addr = 3'($urandom); wdata = W'($urandom); end
                default: ;
            endcase
            step();
            wr_en = 1'b0; rd_en = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
